// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared encodings and sizing helper for the multiply/divide unit
package mdu_pkg;

    // Operation select as driven on the op port
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mdu_state_e;

    // Iteration counter width: wide enough to hold WIDTH itself
    function automatic int mdu_cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// rtl/mdu_div_step.sv - one combinational restoring-division step
module mdu_div_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);

    // Partial remainder is always below the divisor, so the shifted value and
    // the trial difference both fit in WIDTH+1 bits; the top bit is the sign.
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    assign w_shift = {i_rem, i_bit};
    assign w_diff  = w_shift - {1'b0, i_divisor};
    assign o_qbit  = ~w_diff[WIDTH];
    assign o_rem   = o_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO (optional MTHI/MTLO via MDU_MTHILO_EN)
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
`ifdef MDU_MTHILO_EN
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = mdu_cnt_width(WIDTH);

    mdu_state_e         r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    logic               r_done;
    logic               r_is_div;
    logic               r_dz;
    logic               r_neg_q;
    logic               r_neg_r;
    // Multiply: {partial product high, multiplier/low product}.
    // Divide:   {partial remainder, dividend shifting out / quotient shifting in}.
    logic [2*WIDTH-1:0] r_acc;
    // Multiplicand for multiply, divisor for divide (magnitudes).
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_signed;
    logic [WIDTH-1:0]   w_abs_rs;
    logic [WIDTH-1:0]   w_abs_rt;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_upper;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH-1:0]   w_new_rem;
    logic               w_qbit;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_signed = (op == OP_MULT) || (op == OP_DIV);
    assign w_abs_rs = (w_signed && rs[WIDTH-1]) ? -rs : rs;
    assign w_abs_rt = (w_signed && rt[WIDTH-1]) ? -rt : rt;

    // Shift-add step: conditional add into the high half keeps its carry,
    // which becomes the new top bit after the right shift.
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_b};
    assign w_upper    = r_acc[0] ? w_sum : {1'b0, r_acc[2*WIDTH-1:WIDTH]};
    assign w_mul_next = {w_upper, r_acc[WIDTH-1:1]};

    mdu_div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .i_rem     (r_acc[2*WIDTH-1:WIDTH]),
        .i_bit     (r_acc[WIDTH-1]),
        .i_divisor (r_b),
        .o_rem     (w_new_rem),
        .o_qbit    (w_qbit)
    );

    assign w_div_next = {w_new_rem, r_acc[WIDTH-2:0], w_qbit};

    // Sign correction is plain two's complement with wrap, which also makes
    // the most-negative / -1 division come out as 0x80..0 with zero remainder.
    assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
    assign w_quo_fix  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem_fix  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    // Sequencer and datapath: accept in IDLE, iterate in CALC, correct and write in FIX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_is_div <= 1'b0;
            r_dz     <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_acc    <= '0;
            r_b      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                        r_is_div <= op[1];
                        r_neg_q  <= w_signed & (rs[WIDTH-1] ^ rt[WIDTH-1]);
                        r_neg_r  <= w_signed & rs[WIDTH-1];
                        if (op[1]) begin
                            r_b <= w_abs_rt;
                            if (rt == '0) begin
                                // Divide by zero: keep raw rs for HI, finish next edge
                                r_dz    <= 1'b1;
                                r_acc   <= {{WIDTH{1'b0}}, rs};
                                r_state <= FIX;
                            end else begin
                                r_dz    <= 1'b0;
                                r_acc   <= {{WIDTH{1'b0}}, w_abs_rs};
                                r_state <= CALC;
                            end
                        end else begin
                            r_dz    <= 1'b0;
                            r_b     <= w_abs_rs;
                            r_acc   <= {{WIDTH{1'b0}}, w_abs_rt};
                            r_state <= CALC;
                        end
                    end
`ifdef MDU_MTHILO_EN
                    else begin
                        if (hi_we) r_hi <= wdata;
                        if (lo_we) r_lo <= wdata;
                    end
`endif
                end
                CALC: begin
                    r_acc <= r_is_div ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    if (r_dz) begin
                        r_hi <= r_acc[WIDTH-1:0];
                        r_lo <= '1;
                    end else if (r_is_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end else begin
                        {r_hi, r_lo} <= w_prod_fix;
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit in the execute stage, directly downstream of the register bank.
- Consumes the two register read operands (rs, rt) and performs MULT/MULTU/DIV/DIVU.
- Results go into internal HI/LO registers, which the datapath reads for MFHI/MFLO.
- Multi-cycle, so control must stall on busy.

Parameters:
- WIDTH, 32: operand width. HI and LO are each WIDTH bits. Iteration count equals WIDTH.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: operation request. Sampled only when busy=0.
- op, input, 2: operation select. 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- rs, input, WIDTH: operand A (multiplicand or dividend), from register bank read port 1.
- rt, input, WIDTH: operand B (multiplier or divisor), from register bank read port 2.
- busy, output, 1: operation in flight. start is ignored while high.
- done, output, 1: one-cycle pulse when HI/LO hold the new result.
- hi, output, WIDTH: HI register (product upper half or remainder).
- lo, output, WIDTH: LO register (product lower half or quotient).

Interface note: one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0.
  - Any in-flight operation is discarded.
- States:
  - IDLE: wait for start.
  - CALC: WIDTH iterations.
  - FIX: sign correction and write to HI/LO.
- IDLE with start=1 at edge E0:
  - Latch op and |rs|,|rt| (absolute values for signed ops; raw values for unsigned).
  - Record result signs: product sign = rs[MSB]^rt[MSB]; quotient sign = same; remainder sign = rs[MSB].
  - busy=1 from E0 onward. Go to CALC.
- CALC, one iteration per edge (E1..E_WIDTH):
  - MULT: shift-add. If the multiplier LSB is set, add the multiplicand into the 2*WIDTH accumulator, then shift right.
  - DIV: restoring step. Shift the remainder left and bring in the next dividend bit. Trial-subtract the divisor; keep the result if non-negative and set the quotient bit to 1, else quotient bit 0.
  - After iteration WIDTH, go to FIX.
- FIX at edge E_WIDTH+1:
  - Negate the product, quotient or remainder per its recorded sign (two's complement, WIDTH-bit wrap).
  - Write hi/lo.
  - done=1 for exactly one cycle; busy=0 in the same cycle. Go to IDLE.
- Latency: done is high in the cycle after edge E(WIDTH+1), i.e. 33 edges after the accepting edge for WIDTH=32.
- Divide by zero (rt=0, DIV or DIVU):
  - Detected at E0; CALC and FIX are skipped.
  - At E1: hi=rs, lo={WIDTH{1}}, done=1, busy=0.
- Signed overflow (DIV, rs=0x80000000, rt=0xFFFFFFFF): lo=0x80000000, hi=0. This falls out of the wrap arithmetic with no special case.
- hi/lo hold their value except at FIX, the divide-by-zero completion, or the optional writes.
- start asserted in the same cycle done=1 is accepted (busy=0 then); back-to-back issue is legal.
- start while busy=1 is ignored. No queuing, no error flag.
- Operands are captured at E0; later changes to rs/rt have no effect.

Optional Feature:
- Macro: MDU_MTHILO_EN.
- When defined, three extra input ports are added:
  - hi_we, 1 bit.
  - lo_we, 1 bit.
  - wdata, WIDTH bits.
- Write rules:
  - When busy=0 and start=0, hi_we/lo_we load wdata into hi/lo at the next edge (MTHI/MTLO). Both may be set together.
  - Writes are ignored while busy=1 or when start=1 (start wins).
- When undefined: the ports are absent and hi/lo change only through operations.

Decomposition:
- Shared package/include mdu_pkg holds:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - state encodings: IDLE, CALC, FIX.
  - iteration counter width: $clog2(WIDTH)+1.
- One natural sub-module: mdu_div_step. It is a combinational restoring step taking remainder, dividend bit and divisor, and returning the new remainder and quotient bit.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 33 edges, done pulse; hi=0xFFFFFFFE, lo=0x00000001; busy high for edges E0..E32.
- MULT rs=-3 (0xFFFFFFFD), rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV rs=-7, rt=2 issued the cycle done=1 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU rs=100, rt=0 -> at E1, done=1, hi=100, lo=0xFFFFFFFF; busy never high past E1.
- DIV rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0. Also pulse start again mid-CALC with different operands -> ignored, result unchanged.
- Start DIVU 1000/7, assert rst_n=0 at iteration 10 -> immediately busy=0, done=0, hi=lo=0. Re-issue after release -> lo=142, hi=6.
- (MDU_MTHILO_EN) hi_we=1, wdata=0x12345678 while idle -> hi=0x12345678. hi_we during busy -> ignored. hi_we together with start -> the operation result wins.
